cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and the data cache. Merges their cacheline-wide physical-memory ports onto the single pmem port that feeds the cacheline adapter/DRAM model.
- Grants one cache at a time. Holds the granted request stable until pmem responds, then routes the response back to the granted cache only.
- Ties between caches are broken round-robin so neither cache starves.

Parameters:
- LINE_WIDTH, 256, cacheline width in bits for all rdata/wdata buses.
- ADDR_WIDTH, 32, physical address width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- icache_pmem_read  input  1  icache line-fill request
- icache_pmem_address  input  ADDR_WIDTH  icache line address
- icache_pmem_rdata  output  LINE_WIDTH  line returned to icache
- icache_pmem_resp  output  1  icache transaction complete
- dcache_pmem_read  input  1  dcache line-fill request
- dcache_pmem_write  input  1  dcache write-back request
- dcache_pmem_address  input  ADDR_WIDTH  dcache line address
- dcache_pmem_wdata  input  LINE_WIDTH  write-back line
- dcache_pmem_rdata  output  LINE_WIDTH  line returned to dcache
- dcache_pmem_resp  output  1  dcache transaction complete
- pmem_read  output  1  read request to memory
- pmem_write  output  1  write request to memory
- pmem_address  output  ADDR_WIDTH  request address
- pmem_wdata  output  LINE_WIDTH  write data
- pmem_rdata  input  LINE_WIDTH  read data from memory
- pmem_resp  input  1  memory transaction complete

Behaviour:
- Clocking/reset:
  - One clock, clk, rising edge.
  - rst is synchronous and active-high.
  - On reset: state=IDLE, last_grant=DCACHE, latched address/wdata/op cleared to 0.
- Outputs during reset and in IDLE:
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - Both *_resp=0.
  - Both *_rdata=0.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE arbitration, evaluated every cycle:
  - icache request = icache_pmem_read.
  - dcache request = dcache_pmem_read | dcache_pmem_write.
  - Only one requester: grant it.
  - Both requesting: grant the cache that is not last_grant.
  - On grant, at the next edge:
    - latch address, wdata and op (read/write);
    - update last_grant;
    - move to SERVE_I or SERVE_D.
  - No requester: stay in IDLE.
- SERVE_x:
  - pmem_read/pmem_write/pmem_address/pmem_wdata are driven from the latched registers only, so they are stable for the whole transaction.
  - icache transactions: pmem_write=0, pmem_wdata=0.
- Latency:
  - Request sampled in IDLE at cycle t; pmem request visible from cycle t+1.
  - Each transaction adds one arbitration cycle over raw pmem latency.
- Completion:
  - While in SERVE_x with pmem_resp=1, x_pmem_resp=1 in the same cycle (combinational).
  - x_pmem_rdata=pmem_rdata in that cycle; the other cache's resp stays 0 and its rdata stays 0.
  - Next state is IDLE. IDLE always lasts at least one cycle between transactions, giving the cache time to drop its request.
- Boundary conditions:
  - dcache read and write both asserted: write wins; latched op = write.
  - Requester deasserts or changes address mid-transaction: ignored. The latched transaction completes and resp is still pulsed.
  - pmem_resp while in IDLE: ignored; no resp forwarded.
  - rst during SERVE_x: return to IDLE next edge, pmem request dropped, no resp generated, last_grant reset to DCACHE.
  - Back-to-back contention: I and D both held high alternate I, D, I, D…, with the first grant after reset going to I.

Test Plan:
- Reset, then icache_pmem_read=1 at 0x0000_0040 → pmem_read=1, pmem_address=0x40 one cycle later. Memory returns 0xAB… with resp → icache_pmem_resp=1 same cycle with that rdata; dcache_pmem_resp=0.
- dcache_pmem_write=1, addr 0x0000_1000, wdata all-0x5A → pmem_write=1, pmem_read=0, pmem_wdata all-0x5A held until resp → dcache_pmem_resp pulses 1 cycle.
- Both caches request continuously after reset, 4 transactions → grant order I, D, I, D. pmem_address alternates between the two addresses; each transaction is preceded by exactly one IDLE cycle.
- Start icache transaction at 0x80, change icache_pmem_address to 0xC0 mid-transaction → pmem_address stays 0x80 until resp.
- Assert rst while in SERVE_D with pmem_resp not yet given → next cycle pmem_read=pmem_write=0. No dcache_pmem_resp. A later pmem_resp in IDLE produces no resp on either cache.
- dcache asserts read and write together at 0x200 → pmem_write=1, pmem_read=0.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// Signal bundle between the arbiter, the two caches and physical memory.
// The arbiter takes the master view; the surrounding caches/memory take the slave view.
interface cache_mem_arbiter_if #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
);
  logic                  icache_pmem_read;
  logic [ADDR_WIDTH-1:0] icache_pmem_address;
  logic [LINE_WIDTH-1:0] icache_pmem_rdata;
  logic                  icache_pmem_resp;

  logic                  dcache_pmem_read;
  logic                  dcache_pmem_write;
  logic [ADDR_WIDTH-1:0] dcache_pmem_address;
  logic [LINE_WIDTH-1:0] dcache_pmem_wdata;
  logic [LINE_WIDTH-1:0] dcache_pmem_rdata;
  logic                  dcache_pmem_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport master (
    input  icache_pmem_read, icache_pmem_address,
    output icache_pmem_rdata, icache_pmem_resp,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output dcache_pmem_rdata, dcache_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    output icache_pmem_read, icache_pmem_address,
    input  icache_pmem_rdata, icache_pmem_resp,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  dcache_pmem_rdata, dcache_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter merging icache and dcache line traffic onto one pmem port.
// The granted request is latched so pmem sees a stable transaction until pmem_resp.
module cache_mem_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  cache_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_d_q, last_d_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;

  logic i_req_s, d_req_s, grant_d_s;
  logic i_resp_s, d_resp_s;

  // Next-state and arbitration decision
  always_comb begin
    i_req_s   = bus.icache_pmem_read;
    d_req_s   = bus.dcache_pmem_read | bus.dcache_pmem_write;
    // dcache wins only if it is alone or icache was not the previous loser
    grant_d_s = d_req_s & (~i_req_s | ~last_d_q);

    state_d  = state_q;
    last_d_d = last_d_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    read_d   = read_q;
    write_d  = write_q;

    case (state_q)
      IDLE: begin
        if (i_req_s | d_req_s) begin
          state_d  = grant_d_s ? SERVE_D : SERVE_I;
          last_d_d = grant_d_s;
          addr_d   = grant_d_s ? bus.dcache_pmem_address : bus.icache_pmem_address;
          wdata_d  = grant_d_s ? bus.dcache_pmem_wdata : {LINE_WIDTH{1'b0}};
          write_d  = grant_d_s & bus.dcache_pmem_write;
          read_d   = ~(grant_d_s & bus.dcache_pmem_write);
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        // Clearing the latch on completion keeps pmem outputs at zero in IDLE
        if (bus.pmem_resp) begin
          state_d = IDLE;
          addr_d  = {ADDR_WIDTH{1'b0}};
          wdata_d = {LINE_WIDTH{1'b0}};
          read_d  = 1'b0;
          write_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = {ADDR_WIDTH{1'b0}};
        wdata_d = {LINE_WIDTH{1'b0}};
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // State and latched-transaction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      addr_q   <= {ADDR_WIDTH{1'b0}};
      wdata_q  <= {LINE_WIDTH{1'b0}};
      read_q   <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      read_q   <= read_d;
      write_q  <= write_d;
    end
  end

  assign bus.pmem_read    = read_q;
  assign bus.pmem_write   = write_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  assign i_resp_s = ~rst & (state_q == SERVE_I) & bus.pmem_resp;
  assign d_resp_s = ~rst & (state_q == SERVE_D) & bus.pmem_resp;

  assign bus.icache_pmem_resp  = i_resp_s;
  assign bus.icache_pmem_rdata = i_resp_s ? bus.pmem_rdata : {LINE_WIDTH{1'b0}};
  assign bus.dcache_pmem_resp  = d_resp_s;
  assign bus.dcache_pmem_rdata = d_resp_s ? bus.pmem_rdata : {LINE_WIDTH{1'b0}};

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios with literal expectations, then
// random traffic, all checked every cycle against a transaction-level model.
module tb_cache_mem_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

  cache_mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Transaction-level model: one outstanding transaction, owner and its latched request
  bit          m_act    = 1'b0;
  bit          m_own_d  = 1'b0;
  bit          m_last_d = 1'b1;
  bit          m_write  = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0;

  always @(posedge clk) begin
    bit ireq, dreq, pick_d;
    ireq = bus.icache_pmem_read;
    dreq = bus.dcache_pmem_read || bus.dcache_pmem_write;
    if (rst) begin
      m_act    = 1'b0;
      m_last_d = 1'b1;
    end else if (m_act) begin
      if (bus.pmem_resp) m_act = 1'b0;
    end else if (ireq || dreq) begin
      if (ireq && dreq) pick_d = !m_last_d;
      else              pick_d = dreq;
      m_act    = 1'b1;
      m_own_d  = pick_d;
      m_last_d = pick_d;
      m_addr   = pick_d ? bus.dcache_pmem_address : bus.icache_pmem_address;
      m_write  = pick_d && bus.dcache_pmem_write;
      m_wdata  = pick_d ? bus.dcache_pmem_wdata : '0;
    end
  end

  task automatic cmp(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model (called at negedge)
  task automatic check_cycle();
    bit            resp_ok;
    logic [LW-1:0] zero_line;
    @(negedge clk);
    zero_line = '0;
    resp_ok = !rst && m_act && bus.pmem_resp;
    cmp("pmem_read",    LW'(bus.pmem_read),    LW'(m_act && !m_write));
    cmp("pmem_write",   LW'(bus.pmem_write),   LW'(m_act && m_write));
    cmp("pmem_address", LW'(bus.pmem_address), m_act ? LW'(m_addr) : zero_line);
    cmp("pmem_wdata",   bus.pmem_wdata,        m_act ? m_wdata : zero_line);
    cmp("icache_resp",  LW'(bus.icache_pmem_resp), LW'(resp_ok && !m_own_d));
    cmp("dcache_resp",  LW'(bus.dcache_pmem_resp), LW'(resp_ok && m_own_d));
    cmp("icache_rdata", bus.icache_pmem_rdata, (resp_ok && !m_own_d) ? bus.pmem_rdata : zero_line);
    cmp("dcache_rdata", bus.dcache_pmem_rdata, (resp_ok && m_own_d) ? bus.pmem_rdata : zero_line);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.icache_pmem_read    = 1'b0;
    bus.icache_pmem_address = '0;
    bus.dcache_pmem_read    = 1'b0;
    bus.dcache_pmem_write   = 1'b0;
    bus.dcache_pmem_address = '0;
    bus.dcache_pmem_wdata   = '0;
    bus.pmem_resp           = 1'b0;
    bus.pmem_rdata          = '0;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [LW-1:0] line_ab, line_5a;
    logic [AW-1:0] exp_addr;
    line_ab = {32{8'hAB}};
    line_5a = {32{8'h5A}};
    rst = 1'b1;
    idle_inputs();
    adv();

    // Reset state
    check_cycle();
    cmp("rst_pmem_read", LW'(bus.pmem_read), LW'(1'b0));
    cmp("rst_pmem_addr", LW'(bus.pmem_address), LW'(32'h0));
    adv();
    rst = 1'b0;

    // icache read at 0x40
    bus.icache_pmem_read = 1'b1;
    bus.icache_pmem_address = 32'h0000_0040;
    check_cycle();
    cmp("t1_idle_read", LW'(bus.pmem_read), LW'(1'b0));
    adv();
    check_cycle();
    cmp("t1_pmem_read", LW'(bus.pmem_read), LW'(1'b1));
    cmp("t1_pmem_addr", LW'(bus.pmem_address), LW'(32'h40));
    adv();
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = line_ab;
    check_cycle();
    cmp("t1_i_resp", LW'(bus.icache_pmem_resp), LW'(1'b1));
    cmp("t1_i_rdata", bus.icache_pmem_rdata, line_ab);
    cmp("t1_d_resp", LW'(bus.dcache_pmem_resp), LW'(1'b0));
    adv();
    idle_inputs();
    check_cycle();
    adv();

    // dcache write-back at 0x1000
    bus.dcache_pmem_write = 1'b1;
    bus.dcache_pmem_address = 32'h0000_1000;
    bus.dcache_pmem_wdata = line_5a;
    check_cycle();
    adv();
    for (int k = 0; k < 2; k++) begin
      check_cycle();
      cmp("t2_pmem_write", LW'(bus.pmem_write), LW'(1'b1));
      cmp("t2_pmem_read", LW'(bus.pmem_read), LW'(1'b0));
      cmp("t2_pmem_wdata", bus.pmem_wdata, line_5a);
      adv();
    end
    bus.pmem_resp = 1'b1;
    check_cycle();
    cmp("t2_d_resp", LW'(bus.dcache_pmem_resp), LW'(1'b1));
    adv();
    idle_inputs();
    check_cycle();
    cmp("t2_d_resp_pulse", LW'(bus.dcache_pmem_resp), LW'(1'b0));
    adv();

    // Contention after reset: I, D, I, D with one IDLE cycle each
    rst = 1'b1;
    check_cycle();
    adv();
    rst = 1'b0;
    bus.icache_pmem_read = 1'b1;
    bus.icache_pmem_address = 32'h0000_0100;
    bus.dcache_pmem_read = 1'b1;
    bus.dcache_pmem_address = 32'h0000_0300;
    for (int k = 0; k < 4; k++) begin
      exp_addr = (k % 2 == 0) ? 32'h100 : 32'h300;
      check_cycle();
      cmp("t3_idle_gap", LW'(bus.pmem_read), LW'(1'b0));
      adv();
      check_cycle();
      cmp("t3_grant_addr", LW'(bus.pmem_address), LW'(exp_addr));
      adv();
      bus.pmem_resp = 1'b1;
      bus.pmem_rdata = rand_line();
      check_cycle();
      cmp("t3_i_resp", LW'(bus.icache_pmem_resp), LW'(k % 2 == 0));
      cmp("t3_d_resp", LW'(bus.dcache_pmem_resp), LW'(k % 2 == 1));
      adv();
      bus.pmem_resp = 1'b0;
    end
    idle_inputs();

    // icache address change mid-transaction is ignored
    bus.icache_pmem_read = 1'b1;
    bus.icache_pmem_address = 32'h0000_0080;
    check_cycle();
    adv();
    bus.icache_pmem_address = 32'h0000_00C0;
    for (int k = 0; k < 2; k++) begin
      check_cycle();
      cmp("t4_addr_held", LW'(bus.pmem_address), LW'(32'h80));
      adv();
    end
    bus.pmem_resp = 1'b1;
    check_cycle();
    cmp("t4_i_resp", LW'(bus.icache_pmem_resp), LW'(1'b1));
    adv();
    idle_inputs();

    // Reset during SERVE_D drops the request; later pmem_resp is ignored
    bus.dcache_pmem_read = 1'b1;
    bus.dcache_pmem_address = 32'h0000_0400;
    check_cycle();
    adv();
    check_cycle();
    cmp("t5_serving", LW'(bus.pmem_read), LW'(1'b1));
    adv();
    rst = 1'b1;
    check_cycle();
    adv();
    rst = 1'b0;
    bus.dcache_pmem_read = 1'b0;
    check_cycle();
    cmp("t5_read_drop", LW'(bus.pmem_read), LW'(1'b0));
    cmp("t5_write_drop", LW'(bus.pmem_write), LW'(1'b0));
    adv();
    bus.pmem_resp = 1'b1;
    check_cycle();
    cmp("t5_no_d_resp", LW'(bus.dcache_pmem_resp), LW'(1'b0));
    cmp("t5_no_i_resp", LW'(bus.icache_pmem_resp), LW'(1'b0));
    adv();
    idle_inputs();

    // dcache read+write together: write wins
    bus.dcache_pmem_read = 1'b1;
    bus.dcache_pmem_write = 1'b1;
    bus.dcache_pmem_address = 32'h0000_0200;
    check_cycle();
    adv();
    check_cycle();
    cmp("t6_write_wins", LW'(bus.pmem_write), LW'(1'b1));
    cmp("t6_no_read", LW'(bus.pmem_read), LW'(1'b0));
    adv();
    bus.pmem_resp = 1'b1;
    check_cycle();
    cmp("t6_d_resp", LW'(bus.dcache_pmem_resp), LW'(1'b1));
    adv();
    idle_inputs();

    // Random traffic, including spurious resp and occasional reset
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.icache_pmem_read    = ($urandom_range(0, 2) != 0);
      bus.icache_pmem_address = $urandom & 32'hFFFF_FFE0;
      bus.dcache_pmem_read    = ($urandom_range(0, 2) == 0);
      bus.dcache_pmem_write   = ($urandom_range(0, 2) == 0);
      bus.dcache_pmem_address = $urandom & 32'hFFFF_FFE0;
      bus.dcache_pmem_wdata   = rand_line();
      bus.pmem_resp           = ($urandom_range(0, 3) == 0);
      bus.pmem_rdata          = rand_line();
      check_cycle();
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
